// File: rtl/paraseri.sv
// -----------------------------------------------------------------------------
// paraseri -- parallel-to-serial transmitter, MSB first.
//
// A WIDTH-bit word on pd is accepted on a rising edge where ld=1 and rdy=1.
// Its bits then appear on so, one per cycle, starting in the cycle after the
// accepting edge. ena is high for exactly those WIDTH cycles. done pulses for
// one cycle after the last bit of each word.
//
// Ports:
//   clk  in   1      clock; all state changes on the rising edge
//   res  in   1      reset, synchronous, active-low
//   ld   in   1      load request
//   pd   in   WIDTH  parallel data, sampled only on an accepting edge
//   so   out  1      serial data (0 while idle)
//   ena  out  1      bit-valid, high exactly while so carries a data bit
//   rdy  out  1      a word can be accepted on the coming edge
//   done out  1      one-cycle pulse after the last bit of a word
//
// Optional feature: define PARASERI_DBUF_EN to add a one-word holding register
// (hold/pend). Words then follow each other with no idle gap. rdy becomes
// ~pend in every state. Without the macro there is no hold/pend logic, and
// rdy is high only in IDLE. That leaves at least one idle cycle between words.
//
// All outputs come straight from flops. Each flop is loaded with the value
// its output must show in the next cycle.
// -----------------------------------------------------------------------------
module paraseri #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             res,
    input  logic             ld,
    input  logic [WIDTH-1:0] pd,
    output logic             so,
    output logic             ena,
    output logic             rdy,
    output logic             done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             so_q, so_d;
    logic             ena_q, ena_d;
    logic             rdy_q, rdy_d;
    logic             done_q, done_d;
    logic             accept_s;
`ifdef PARASERI_DBUF_EN
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             pend_q, pend_d;
`endif

    assign accept_s = ld & rdy_q;

    // Next-state logic for the sequencer, including the registered output values.
    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
`ifdef PARASERI_DBUF_EN
        hold_d  = hold_q;
        pend_d  = pend_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    sreg_d  = pd;
                    cnt_d   = CNT_LAST;
                    state_d = SHIFT;
                end else begin
                    sreg_d  = sreg_q;
                end
            end
            SHIFT: begin
                if (cnt_q != {CW{1'b0}}) begin
                    sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
                    cnt_d  = cnt_q - CW'(1);
`ifdef PARASERI_DBUF_EN
                    // Park the next word until the current one finishes.
                    if (accept_s) begin
                        hold_d = pd;
                        pend_d = 1'b1;
                    end else begin
                        hold_d = hold_q;
                    end
`endif
                end else begin
                    done_d = 1'b1;
`ifdef PARASERI_DBUF_EN
                    // Chain the parked word, or a fresh one, with no gap.
                    if (pend_q) begin
                        sreg_d = hold_q;
                        pend_d = 1'b0;
                        cnt_d  = CNT_LAST;
                    end else if (accept_s) begin
                        sreg_d = pd;
                        cnt_d  = CNT_LAST;
                    end else begin
                        state_d = IDLE;
                    end
`else
                    state_d = IDLE;
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        ena_d = (state_d == SHIFT);
        so_d  = ena_d ? sreg_d[WIDTH-1] : 1'b0;
`ifdef PARASERI_DBUF_EN
        rdy_d = ~pend_d;
`else
        rdy_d = (state_d == IDLE);
`endif
    end

    // State and output registers, with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!res) begin
            state_q <= IDLE;
            sreg_q  <= {WIDTH{1'b0}};
            cnt_q   <= {CW{1'b0}};
            so_q    <= 1'b0;
            ena_q   <= 1'b0;
            rdy_q   <= 1'b1;
            done_q  <= 1'b0;
`ifdef PARASERI_DBUF_EN
            hold_q  <= {WIDTH{1'b0}};
            pend_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
            so_q    <= so_d;
            ena_q   <= ena_d;
            rdy_q   <= rdy_d;
            done_q  <= done_d;
`ifdef PARASERI_DBUF_EN
            hold_q  <= hold_d;
            pend_q  <= pend_d;
`endif
        end
    end

    assign so   = so_q;
    assign ena  = ena_q;
    assign rdy  = rdy_q;
    assign done = done_q;

endmodule

// File: tb/tb_paraseri.sv
// -----------------------------------------------------------------------------
// tb_paraseri -- self-checking bench for paraseri (WIDTH=4).
// The model is a queue of bits still to be transmitted. Each entry is tagged
// with its word and an end-of-word flag. A small receiver shifts so in on
// every ena cycle. Define PARASERI_DBUF_EN for both files to exercise the
// double-buffered variant.
// -----------------------------------------------------------------------------
module tb_paraseri;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         res = 1'b1;
    logic         ld  = 1'b0;
    logic [W-1:0] pd  = '0;
    logic         so, ena, rdy, done;

    paraseri #(.WIDTH(W)) dut (
        .clk (clk),
        .res (res),
        .ld  (ld),
        .pd  (pd),
        .so  (so),
        .ena (ena),
        .rdy (rdy),
        .done(done)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int fails   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic         b;
        logic         last;
        logic [W-1:0] w;
    } ent_t;

    ent_t         q_m[$];
    logic         m_so   = 1'b0;
    logic         m_ena  = 1'b0;
    logic         m_rdy  = 1'b1;
    logic         m_done = 1'b0;
    logic [W-1:0] m_word = '0;
    logic         armed  = 1'b0;

    task automatic model_step(input logic l, input logic r, input logic [W-1:0] d,
                              output logic o_so, output logic o_ena, output logic o_rdy,
                              output logic o_done, inout logic [W-1:0] o_word);
        ent_t e;
        logic acc;
        o_done = 1'b0;
        if (!r) begin
            q_m.delete();
        end else begin
            acc = l && m_rdy;
            if (q_m.size() > 0) begin
                e = q_m.pop_front();
                if (e.last) begin
                    o_done = 1'b1;
                    o_word = e.w;
                end
            end
            if (acc) begin
                for (int i = W - 1; i >= 0; i--) begin
                    e.b    = d[i];
                    e.last = (i == 0);
                    e.w    = d;
                    q_m.push_back(e);
                end
            end
        end
        o_ena = (q_m.size() > 0);
        o_so  = o_ena ? q_m[0].b : 1'b0;
`ifdef PARASERI_DBUF_EN
        o_rdy = (q_m.size() <= W);
`else
        o_rdy = (q_m.size() == 0);
`endif
    endtask

    // Advance the model on each rising edge from the inputs the DUT sees.
    always @(posedge clk) begin : model_blk
        logic t_so, t_ena, t_rdy, t_done;
        logic [W-1:0] t_word;
        t_word = m_word;
        model_step(ld, res, pd, t_so, t_ena, t_rdy, t_done, t_word);
        m_so   <= t_so;
        m_ena  <= t_ena;
        m_rdy  <= t_rdy;
        m_done <= t_done;
        m_word <= t_word;
        if (!res) armed <= 1'b1;
    end

    // Chained receiver: shifts so in on every ena cycle.
    logic [W-1:0] rx = '0;
    always @(posedge clk) begin
        if (ena) rx <= {rx[W-2:0], so};
    end

    // Every-cycle compare against the model, plus the capture of the transmitted stream.
    logic [15:0] cap    = '0;
    int          n_ena  = 0;
    int          n_done = 0;
    always @(negedge clk) begin
        if (armed) begin
            check("so",   {31'd0, so},   {31'd0, m_so});
            check("ena",  {31'd0, ena},  {31'd0, m_ena});
            check("rdy",  {31'd0, rdy},  {31'd0, m_rdy});
            check("done", {31'd0, done}, {31'd0, m_done});
            if (m_done) check("rx_q", {28'd0, rx}, {28'd0, m_word});
            if (ena) begin
                cap   <= {cap[14:0], so};
                n_ena <= n_ena + 1;
            end
            if (done) n_done <= n_done + 1;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    int b_ena, b_done;
    task automatic mark();
        b_ena  = n_ena;
        b_done = n_done;
    endtask

    logic [W-1:0] words[6] = '{4'h9, 4'h6, 4'h0, 4'hF, 4'h3, 4'h8};

    initial begin
        // Reset.
        res = 1'b0; ld = 1'b0; pd = '0;
        cyc(2);
        res = 1'b1;
        check("reset_ena",  {31'd0, ena},  32'd0);
        check("reset_so",   {31'd0, so},   32'd0);
        check("reset_rdy",  {31'd0, rdy},  32'd1);
        check("reset_done", {31'd0, done}, 32'd0);

        // Single word 1100.
        mark();
        ld = 1'b1; pd = 4'b1100;
        cyc(1);
        ld = 1'b0;
        cyc(6);
        check("w1100_bits", {28'd0, cap[3:0]}, 32'hC);
        check("w1100_ena",  n_ena - b_ena,     32'd4);
        check("w1100_done", n_done - b_done,   32'd1);
        check("w1100_rdy",  {31'd0, rdy},      32'd1);
        check("w1100_rx",   {28'd0, rx},       32'hC);

`ifndef PARASERI_DBUF_EN
        // ld during bit 2 is ignored.
        mark();
        ld = 1'b1; pd = 4'b1010;
        cyc(1);
        ld = 1'b0;
        cyc(1);
        ld = 1'b1; pd = 4'b0101;
        cyc(1);
        ld = 1'b0;
        cyc(8);
        check("busy_ld_bits", {28'd0, cap[3:0]}, 32'hA);
        check("busy_ld_ena",  n_ena - b_ena,     32'd4);
        check("busy_ld_done", n_done - b_done,   32'd1);
`endif

        // Reset after bit 2 aborts the word.
        mark();
        ld = 1'b1; pd = 4'b1111;
        cyc(1);
        ld = 1'b0;
        cyc(1);
        res = 1'b0;
        cyc(1);
        res = 1'b1;
        check("abort_ena", {31'd0, ena}, 32'd0);
        check("abort_so",  {31'd0, so},  32'd0);
        check("abort_rdy", {31'd0, rdy}, 32'd1);
        cyc(6);
        check("abort_done", n_done - b_done, 32'd0);
        check("abort_nena", n_ena - b_ena,   32'd2);

        // Reset wins over ld on the same edge.
        mark();
        res = 1'b0; ld = 1'b1; pd = 4'b1001;
        cyc(1);
        res = 1'b1; ld = 1'b0;
        cyc(6);
        check("rst_ld_ena", n_ena - b_ena, 32'd0);
        check("rst_ld_rdy", {31'd0, rdy},  32'd1);

        // Word stream. pd toggles while busy, and that must not leak onto so.
        foreach (words[i]) begin
            ld = 1'b1; pd = words[i];
            cyc(1);
            ld = 1'b0;
            for (int c = 0; c < 6; c++) begin
                pd = ~words[i] ^ W'(c);
                cyc(1);
            end
            check("stream_bits", {28'd0, cap[3:0]}, {28'd0, words[i]});
        end

        // ld held high: the model checks the spacing between words.
        ld = 1'b1; pd = 4'hA;
        cyc(12);
        ld = 1'b0;
        cyc(8);

`ifdef PARASERI_DBUF_EN
        // Second word during bit 1 is chained with no gap.
        mark();
        ld = 1'b1; pd = 4'b1010;
        cyc(1);
        pd = 4'b0110;
        cyc(1);
        ld = 1'b0;
        check("dbuf_pend_rdy", {31'd0, rdy}, 32'd0);
        cyc(10);
        check("dbuf_bits", {24'd0, cap[7:0]}, 32'hA6);
        check("dbuf_ena",  n_ena - b_ena,     32'd8);
        check("dbuf_done", n_done - b_done,   32'd2);

        // ld held high over three words gives a continuous 12-bit stream.
        begin : cont
            logic [W-1:0] cw[3] = '{4'b0011, 4'b1101, 4'b0110};
            int  k;
            logic fin;
            mark();
            fin = 1'b0;
            ld = 1'b1; pd = cw[0]; k = 1;
            for (int c = 0; c < 40 && !fin; c++) begin
                cyc(1);
                if (rdy) begin
                    if (k < 3) begin
                        pd = cw[k];
                        k++;
                    end else begin
                        ld  = 1'b0;
                        fin = 1'b1;
                    end
                end
            end
            ld = 1'b0;
            check("cont_finished", {31'd0, fin}, 32'd1);
            cyc(10);
            check("cont_bits", {20'd0, cap[11:0]}, 32'h3D6);
            check("cont_ena",  n_ena - b_ena,      32'd12);
            check("cont_done", n_done - b_done,    32'd3);
        end
`endif

        cyc(2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule

// File: doc/paraseri.md
PARASERI -- requirements
Module: paraseri

Interface
REQ-001 SHALL have parameter WIDTH, default 4, meaning word length in bits (legal range 2..16).
REQ-002 SHALL have port clk  input  1  clock; all state changes on rising edge.
REQ-003 SHALL have port res  input  1  reset; synchronous, active-low.
REQ-004 SHALL have port ld  input  1  load request; word accepted on a rising edge where ld=1 and rdy=1.
REQ-005 SHALL have port pd  input  WIDTH  parallel data, sampled only on an accepting edge.
REQ-006 SHALL have port so  output  1  serial data, MSB first; drives a seripara si.
REQ-007 SHALL have port ena  output  1  bit-valid; drives a seripara ena, high exactly while so carries a data bit.
REQ-008 SHALL have port rdy  output  1  block can accept a word this cycle.
REQ-009 SHALL have port done  output  1  one-cycle pulse after the last bit of each word.

Function
REQ-010 SHALL implement states IDLE and SHIFT, a WIDTH-bit shift register sreg, and a bit counter cnt of ceil(log2(WIDTH)) bits.
REQ-011 SHALL drive so = sreg[WIDTH-1] in SHIFT and so = 0 in IDLE; ena = 1 iff state is SHIFT; all outputs glitch-free from registers.
REQ-012 SHALL, on an accepting edge in IDLE, set sreg <= pd, cnt <= WIDTH-1, state <= SHIFT; first bit visible in the following cycle (latency 1).
REQ-013 SHALL, on each SHIFT edge with cnt != 0, shift sreg left by one (0 into bit 0) and decrement cnt.
REQ-014 SHALL, on the SHIFT edge with cnt = 0, return to IDLE and assert done for exactly the next cycle; ena is high for exactly WIDTH consecutive cycles per word.
REQ-015 SHALL, without double buffering, drive rdy = 1 iff state is IDLE; ld while rdy=0 SHALL have no effect on any state.
REQ-016 SHALL leave sreg unchanged in IDLE when ld=0; pd changes outside accepting edges SHALL not affect so.
REQ-017 SHALL produce, when so/ena/clk feed a seripara of equal WIDTH, the receiver q equal to the transmitted pd after the last ena cycle.

Reset
REQ-018 SHALL, on a rising edge with res=0, set state=IDLE, sreg=0, cnt=0, done=0, and clear any buffered word; outputs so=0, ena=0, and rdy=1 in the following cycle.
REQ-019 SHALL give reset priority over ld on the same edge; the word presented on that edge is discarded.
REQ-020 SHALL abort a word in progress on reset without asserting done for it.

Configuration
REQ-021 SHALL, when macro PARASERI_DBUF_EN is defined, add a WIDTH-bit holding register hold and flag pend; rdy = ~pend in any state.
REQ-022 SHALL, with PARASERI_DBUF_EN, on an accepting edge in SHIFT with cnt != 0, set hold <= pd and pend <= 1.
REQ-023 SHALL, with PARASERI_DBUF_EN, on the final-bit edge: if pend=1, load sreg <= hold, clear pend, stay in SHIFT; else if ld=1, load sreg <= pd and stay in SHIFT; cnt <= WIDTH-1 in both cases, done pulses, and ena remains high with no gap.
REQ-024 SHALL, without PARASERI_DBUF_EN, contain no hold/pend logic and behave per REQ-015, with a minimum one IDLE cycle between words.

Verification
REQ-025 SHALL verify: reset, then ld=1 pd=4'b1100 for one edge -> so 1,1,0,0 on 4 consecutive ena=1 cycles, done=1 the next cycle, rdy=1 again; chained seripara q=4'b1100.
REQ-026 SHALL verify: load 4'b1010, pulse ld with pd=4'b0101 during bit 2 (no DBUF) -> sequence 1,0,1,0 unaffected, second word never sent.
REQ-027 SHALL verify: load 4'b1111, res=0 for one edge after bit 2 -> ena=0, so=0 next cycle, no done pulse, rdy=1.
REQ-028 SHALL verify: res=0 and ld=1 with pd=4'b1001 on the same edge -> remains IDLE, ena never asserts.
REQ-029 SHALL verify (PARASERI_DBUF_EN): load 4'b1010, then 4'b0110 during bit 1 -> ena high 8 consecutive cycles, so 1,0,1,0,0,1,1,0, done pulses twice, rdy=0 while pend=1.
REQ-030 SHALL verify (PARASERI_DBUF_EN): ld held high with new pd each time rdy=1 over 3 words -> continuous ena for 12 cycles, chained seripara q equals each word at its done pulse.
